fetch_queue: RTL



---
 rtl/pipes.sv | 32 +++
 rtl/fetch_fifo.sv | 92 +++++++++
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipes.sv
// Shared types for the instruction-fetch front end: bus request/response
// structs, the prefetch queue entry and the fetch FSM state encoding.
package pipes;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    localparam logic [63:0] PC_STEP = 64'd4;

    // Sequential successor of a fetch address; wraps modulo 2^64.
    function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue of fetch entries. Flush has priority over push/pop;
// a push into a full queue or a pop from an empty queue is ignored.
module fetch_fifo
    import pipes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy and compute next pointers/count.
    always_comb begin
        do_push_s = push && !flush && (count_q < CNT_W'(DEPTH));
        do_pop_s  = pop  && !flush && (count_q != '0);
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (do_pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage write: only the tail slot changes, and only on an accepted push.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[tail_q] = push_entry;
        end else begin
            mem_d[tail_q] = mem_q[tail_q];
        end
    end

    // Queue state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Head entry and occupancy straight from the registers.
    always_comb begin
        head_entry = mem_q[head_q];
        count      = count_q;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch PC, single outstanding bus
// request held stable until data_ok, prefetch queue towards decode, and
// redirect handling that flushes the queue and drops in-flight responses.
// Optional: define FETCH_BYPASS_EN to hand a response straight to decode
// in its data_ok cycle when the queue is empty (zero-latency bypass).
module fetch_queue
    import pipes::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_state_t     state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic             req_valid_q, req_valid_d;
    logic [63:0]      req_addr_q, req_addr_d;

    logic             complete_s;
    logic             bypass_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             pop_s;
    logic             issue_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [CNT_W-1:0] cnt_after_push_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .head_entry (head_s),
        .count      (fifo_count_s)
    );

    // Response acceptance, decode-side steering and queue push/pop control.
    always_comb begin
        complete_s   = (state_q == RUN) && req_valid_q && iresp.data_ok && !redirect_valid;
        fifo_empty_s = (fifo_count_s == '0);
`ifdef FETCH_BYPASS_EN
        bypass_s     = complete_s && fifo_empty_s;
`else
        bypass_s     = 1'b0;
`endif
        push_entry_s = '{pc: req_addr_q, instr: iresp.data};
        if (bypass_s) begin
            out_valid = 1'b1;
            out_pc    = req_addr_q;
            out_instr = iresp.data;
        end else begin
            // A redirect hides the head in the same cycle so decode never sees a stale entry.
            out_valid = !fifo_empty_s && !redirect_valid;
            out_pc    = head_s.pc;
            out_instr = head_s.instr;
        end
        push_s = complete_s && !(bypass_s && out_ready);
        pop_s  = !bypass_s && !fifo_empty_s && out_ready && !redirect_valid;
    end

    // Fetch FSM next state, fetch PC and bus request control.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        req_valid_d      = req_valid_q;
        req_addr_d       = req_addr_q;
        issue_s          = 1'b0;
        // Occupancy after this cycle's push, ignoring any pop: a new request is
        // only issued when its response is guaranteed a free slot.
        cnt_after_push_s = fifo_count_s + CNT_W'(push_s);
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    if (req_valid_q && !iresp.data_ok) begin
                        state_d = DISCARD;
                        issue_s = 1'b0;
                    end else begin
                        state_d = RUN;
                        issue_s = 1'b1;
                    end
                end else if (complete_s) begin
                    fetch_pc_d = next_seq_pc(fetch_pc_q);
                    issue_s    = (cnt_after_push_s < CNT_W'(DEPTH));
                end else if (!req_valid_q) begin
                    issue_s = (fifo_count_s < CNT_W'(DEPTH));
                end else begin
                    issue_s = 1'b0;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (iresp.data_ok) begin
                    state_d = RUN;
                    issue_s = 1'b1;
                end else begin
                    state_d = DISCARD;
                    issue_s = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
                issue_s = 1'b0;
            end
        endcase

        if (issue_s) begin
            req_valid_d = 1'b1;
            req_addr_d  = fetch_pc_d;
        end else if (req_valid_q && iresp.data_ok) begin
            req_valid_d = 1'b0;
        end else begin
            req_valid_d = req_valid_q;
        end
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

    // Bus request comes straight from registers so it is stable all cycle.
    always_comb begin
        ireq.valid = req_valid_q;
        ireq.addr  = req_addr_q;
    end

endmodule
